// File: rtl/alu_seq_exec_pkg.sv
// alu_pkg: shared constants and types for the multicycle ALU execution unit.
//   - datapath / shift-amount widths
//   - ALU op codes (1 and 3 are undefined and produce result 0)
//   - shift control word bit positions inside operand B
//   - FSM state enum
package alu_pkg;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SUB   = 3'd5;
    localparam logic [2:0] OP_SHIFT = 3'd6;
    localparam logic [2:0] OP_SLT   = 3'd7;

    // Shift control word carried in B: B[3:0]=shamt, B[6]=right, B[5]=logical fill
    localparam int SH_RIGHT   = 6;
    localparam int SH_LOGICAL = 5;
    localparam int SHAMT_HI   = 3;
    localparam int SHAMT_LO   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_exec_if.sv
// alu_seq_exec_if: request/response bundle between the main control FSM
// (master) and the ALU execution unit (slave).
//   start, op, a, b             : request from master
//   busy, done, result, zero,
//   overflow                    : status/result from slave
interface alu_seq_exec_if;
    import alu_pkg::*;

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output start, op, a, b,
        input  busy, done, result, zero, overflow
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero, overflow
    );

endinterface

// File: rtl/alu_seq_exec_shift_step.sv
// shift_step: combinational fixed-distance shifter.
//   din     : data in
//   right   : 0 = shift left (zero fill), 1 = shift right
//   logical : right shifts only; 1 = zero fill, 0 = replicate MSB
//   dout    : shifted data
// DIST defaults to 1 (single-bit step); the barrel variant chains
// instances with DIST = 1, 2, 4, 8.
module shift_step #(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             right,
    input  logic             logical,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        if (!right) begin
            dout = {din[WIDTH-1-DIST:0], {DIST{1'b0}}};
        end else if (logical) begin
            dout = {{DIST{1'b0}}, din[WIDTH-1:DIST]};
        end else begin
            dout = {{DIST{din[WIDTH-1]}}, din[WIDTH-1:DIST]};
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multicycle ALU execution unit.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, aborts any operation
//   bus   : alu_seq_exec_if.slave (start/op/a/b in; busy/done/result/
//           zero/overflow out)
// AND/OR/ADD/SUB/SLT and undefined ops complete with done one cycle after
// start. SHIFT iterates one bit per cycle (latency shamt+1).
// Build option: define ALU_BARREL_SHIFT_EN to compute SHIFT with a barrel
// shifter in the start cycle (latency 1 for every shamt).
module alu_seq_exec
    import alu_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    alu_seq_exec_if.slave  bus
);

    state_t           state;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             done;
    logic             busy;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic [WIDTH-1:0] shift_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = bus.b[SHAMT_HI:SHAMT_LO];

`ifdef ALU_BARREL_SHIFT_EN
    logic [WIDTH-1:0] bstage [SHAMT_W+1];

    assign bstage[0] = bus.a;
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_barrel
        logic [WIDTH-1:0] stepped;
        shift_step #(.WIDTH(WIDTH), .DIST(1 << i)) u_step (
            .din     (bstage[i]),
            .right   (bus.b[SH_RIGHT]),
            .logical (bus.b[SH_LOGICAL]),
            .dout    (stepped)
        );
        assign bstage[i+1] = shamt[i] ? stepped : bstage[i];
    end
    assign shift_res = bstage[SHAMT_W];
`else
    logic [WIDTH-1:0]   shreg;
    logic [SHAMT_W-1:0] cnt;
    logic               sh_right;
    logic               sh_logical;
    logic [WIDTH-1:0]   step_out;

    shift_step #(.WIDTH(WIDTH), .DIST(1)) u_step (
        .din     (shreg),
        .right   (sh_right),
        .logical (sh_logical),
        .dout    (step_out)
    );
    // Only the shamt==0 case completes from IDLE, where the result is A.
    assign shift_res = bus.a;
`endif

    // Single-cycle datapath, evaluated on the live request so the
    // accepting edge captures the operands.
    always_comb begin
        sum     = bus.a + bus.b;
        diff    = bus.a - bus.b;
        slt     = $signed(bus.a) < $signed(bus.b);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            OP_AND:   alu_res = bus.a & bus.b;
            OP_OR:    alu_res = bus.a | bus.b;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SHIFT: alu_res = shift_res;
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, slt};
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            shreg      <= '0;
            cnt        <= '0;
            sh_right   <= 1'b0;
            sh_logical <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        busy <= 1'b1;
`ifndef ALU_BARREL_SHIFT_EN
                        if (bus.op == OP_SHIFT && shamt != '0) begin
                            shreg      <= bus.a;
                            cnt        <= shamt;
                            sh_right   <= bus.b[SH_RIGHT];
                            sh_logical <= bus.b[SH_LOGICAL];
                            state      <= SHIFT;
                        end else
`endif
                        begin
                            result   <= alu_res;
                            zero     <= (alu_res == '0);
                            overflow <= alu_ovf;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    shreg <= step_out;
                    cnt   <= cnt - 1'b1;
                    // Last step: publish the shifted value directly so done
                    // lands on the same edge as the final shift.
                    if (cnt == SHAMT_W'(1)) begin
                        result   <= step_out;
                        zero     <= (step_out == '0);
                        overflow <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.result   = result;
    assign bus.zero     = zero;
    assign bus.overflow = overflow;
    assign bus.done     = done;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: self-checking bench for alu_seq_exec.
// Expected values come from a behavioural model using plain integer
// arithmetic and native shift operators. Honours ALU_BARREL_SHIFT_EN.
module tb_alu_seq_exec;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    alu_seq_exec_if bus ();

    alu_seq_exec dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] r;
        logic        z;
        logic        ov;
    } exp_t;

    function automatic exp_t ref_model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int sx, sy, r, n;
        sx = int'($signed(x));
        sy = int'($signed(y));
        n  = int'(y[3:0]);
        e.ov = 1'b0;
        case (o)
            3'd0: e.r = x & y;
            3'd2: e.r = x | y;
            3'd4: begin r = sx + sy; e.r = r[15:0]; e.ov = (r > 32767) || (r < -32768); end
            3'd5: begin r = sx - sy; e.r = r[15:0]; e.ov = (r > 32767) || (r < -32768); end
            3'd7: e.r = (sx < sy) ? 16'h0001 : 16'h0000;
            3'd6: begin
                if (!y[6])     e.r = x << n;
                else if (y[5]) e.r = x >> n;
                else           e.r = $signed(x) >>> n;
            end
            default: e.r = 16'h0000;
        endcase
        e.z = (e.r == 16'h0000);
        return e;
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [15:0] y);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        return (o == 3'd6) ? int'(y[3:0]) + 1 : 1;
`endif
    endfunction

    // Issues one request, scrambles inputs while the unit is busy and
    // measures cycles from the accepting edge to done (0 = timed out).
    task automatic do_op(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                         output int lat, output logic [15:0] res, output logic z, output logic ov,
                         output logic busy1, output logic pulse_ok);
        @(negedge clock);
        bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
        @(posedge clock); #1;
        bus.start = 1'b0;
        busy1 = bus.busy;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(negedge clock);
            bus.op = 3'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
            @(posedge clock); #1;
            lat++;
        end
        if (!bus.done) lat = 0;
        res = bus.result; z = bus.zero; ov = bus.overflow;
        @(posedge clock); #1;
        pulse_ok = !bus.done && !bus.busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        checks++;
        if ({bus.result, bus.zero, bus.overflow} !== 18'h0) begin
            errors++;
            $display("FAIL reset_data: result=%h zero=%b ovf=%b, want 0000 0 0", bus.result, bus.zero, bus.overflow);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [13] = '{3'd4, 3'd5, 3'd7, 3'd6, 3'd6, 3'd6, 3'd6, 3'd1, 3'd3, 3'd0, 3'd2, 3'd5, 3'd7};
        logic [15:0] as  [13] = '{16'h7FFF, 16'h0005, 16'h8000, 16'hF000, 16'hF000, 16'h1234, 16'h0001,
                                  16'hFFFF, 16'h1234, 16'hF0F0, 16'h00F0, 16'h8000, 16'h7FFF};
        logic [15:0] bs  [13] = '{16'h0001, 16'h0005, 16'h0001, 16'h0043, 16'h0063, 16'h0000, 16'h000F,
                                  16'hFFFF, 16'h5678, 16'hFF00, 16'h0F00, 16'h0001, 16'h8000};
        logic [15:0] rs  [13] = '{16'h8000, 16'h0000, 16'h0001, 16'hFE00, 16'h1E00, 16'h1234, 16'h8000,
                                  16'h0000, 16'h0000, 16'hF000, 16'h0FF0, 16'h7FFF, 16'h0000};
        logic        zs  [13] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
        logic        ovs [13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        int lat;
        logic [15:0] res;
        logic z, ov, busy1, pulse_ok;
        for (int i = 0; i < 13; i++) begin
            do_op(ops[i], as[i], bs[i], lat, res, z, ov, busy1, pulse_ok);
            checks++;
            if (lat !== exp_lat(ops[i], bs[i])) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d, want %0d", i, lat, exp_lat(ops[i], bs[i]));
            end
            checks++;
            if ({res, z, ov} !== {rs[i], zs[i], ovs[i]}) begin
                errors++;
                $display("FAIL dir%0d_result: got r=%h z=%b ov=%b, want r=%h z=%b ov=%b",
                         i, res, z, ov, rs[i], zs[i], ovs[i]);
            end
            checks++;
            if (busy1 !== 1'b1 || pulse_ok !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_handshake: busy_after_start=%b pulse_single_and_idle=%b, want 1 1",
                         i, busy1, pulse_ok);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] res, av, bv;
        logic [2:0] o;
        logic z, ov, busy1, pulse_ok;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            o  = 3'($urandom);
            av = 16'($urandom);
            bv = 16'($urandom);
            e  = ref_model(o, av, bv);
            do_op(o, av, bv, lat, res, z, ov, busy1, pulse_ok);
            checks++;
            if (lat !== exp_lat(o, bv) || pulse_ok !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_timing: op=%0d b=%h lat=%0d pulse_ok=%b, want lat=%0d pulse_ok=1",
                         i, o, bv, lat, pulse_ok, exp_lat(o, bv));
            end
            checks++;
            if ({res, z, ov} !== {e.r, e.z, e.ov}) begin
                errors++;
                $display("FAIL rnd%0d_result: op=%0d a=%h b=%h got r=%h z=%b ov=%b, want r=%h z=%b ov=%b",
                         i, o, av, bv, res, z, ov, e.r, e.z, e.ov);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        logic [15:0] res;
        logic z, ov, busy1, pulse_ok;
        do_op(3'd5, 16'h8000, 16'h0001, lat, res, z, ov, busy1, pulse_ok);
        bus.a = 16'h0000; bus.b = 16'h0000; bus.op = 3'd0;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if ({bus.result, bus.zero, bus.overflow, bus.busy} !== {16'h7FFF, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold: got r=%h z=%b ov=%b busy=%b, want r=7fff z=0 ov=1 busy=0",
                     bus.result, bus.zero, bus.overflow, bus.busy);
        end
    endtask

    task automatic test_start_held();
        int cyc;
        exp_t e1, e2;
        e1 = ref_model(3'd6, 16'h00A5, 16'h0005);
        e2 = ref_model(3'd4, 16'h1000, 16'h0234);
        @(negedge clock);
        bus.start = 1'b1; bus.op = 3'd6; bus.a = 16'h00A5; bus.b = 16'h0005;
        @(posedge clock); #1;
        bus.op = 3'd4; bus.a = 16'h1000; bus.b = 16'h0234;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
        end
        checks++;
        if (cyc !== exp_lat(3'd6, 16'h0005) || bus.done !== 1'b1 || bus.result !== e1.r) begin
            errors++;
            $display("FAIL held_first: lat=%0d done=%b r=%h, want lat=%0d done=1 r=%h",
                     cyc, bus.done, bus.result, exp_lat(3'd6, 16'h0005), e1.r);
        end
        @(posedge clock); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL held_gap: done=%b busy=%b, want 0 0", bus.done, bus.busy);
        end
        @(posedge clock); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.result !== e2.r) begin
            errors++;
            $display("FAIL held_second: done=%b r=%h, want done=1 r=%h", bus.done, bus.result, e2.r);
        end
        @(posedge clock); #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL held_pulse: done=%b, want 0", bus.done);
        end
    endtask

    task automatic test_reset_mid_shift();
        int pulses;
        @(negedge clock);
        bus.start = 1'b1; bus.op = 3'd6; bus.a = 16'h0001; bus.b = 16'h000F;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.zero, bus.overflow} !== 20'h0) begin
            errors++;
            $display("FAIL midreset_state: busy=%b done=%b r=%h z=%b ov=%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.zero, bus.overflow);
        end
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (bus.done || bus.busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midreset_quiet: %0d cycles with done/busy, want 0", pulses);
        end
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        checks = 0;
        errors = 0;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.a = 16'h0000;
        bus.b = 16'h0000;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_start_held();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
